// File: rtl/edge_rate_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_rate_meter_pkg: FSM encoding and saturating increment helper.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package edge_rate_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2
  } state_t;

  // Counters up to 32 bits wide share this; callers cast to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] i_val, input logic [31:0] i_max);
    return (i_val >= i_max) ? i_max : (i_val + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rate_meter_sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_edge_det: multi-flop synchroniser with a one-cycle rising-edge pulse. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/edge_rate_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_rate_meter: counts rising edges of an async pin per 2**LOG2GATE clks. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module edge_rate_meter
  import edge_rate_meter_pkg::*;
#(
  parameter int LOG2GATE    = 22,
  parameter int CNT_BITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lock,
  input  logic                sig_in,
  output logic [CNT_BITS-1:0] edge_count,
  output logic                count_ovf,
  output logic                count_vld,
  output logic                busy
);

  localparam int                    c_SET_W   = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [c_SET_W-1:0]    c_SET_END = c_SET_W'(SYNC_STAGES);
  localparam logic [CNT_BITS-1:0]   c_ACC_MAX = '1;
  localparam logic [LOG2GATE-1:0]   c_TMR_END = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_SET_W-1:0]    r_settle;
  logic [LOG2GATE-1:0]   r_timer;
  logic [CNT_BITS-1:0]   r_acc;
  logic                  r_ovf_acc;
  logic [CNT_BITS-1:0]   r_edge_count;
  logic                  r_count_ovf;
  logic                  r_count_vld;
  logic                  w_edge;
  logic                  w_win_end;
  logic                  w_acc_full;
  logic [CNT_BITS-1:0]   w_acc_inc;
  logic                  w_busy;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (sig_in),
    .o_edge (w_edge)
  );

  assign w_acc_full = (r_acc == c_ACC_MAX);
  assign w_acc_inc  = CNT_BITS'(sat_inc(32'(r_acc), 32'(c_ACC_MAX)));
  // A lock drop on the final cycle discards the window like any other cycle.
  assign w_win_end  = (r_state == ST_GATE) && lock && (r_timer == c_TMR_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (lock) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!lock) begin
          w_state_nxt = ST_IDLE;
        end else if (r_settle == c_SET_END) begin
          w_state_nxt = ST_GATE;
        end
      end
      ST_GATE:   if (!lock) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_GATE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle     <= '0;
      r_timer      <= '0;
      r_acc        <= '0;
      r_ovf_acc    <= 1'b0;
      r_edge_count <= '0;
      r_count_ovf  <= 1'b0;
      r_count_vld  <= 1'b0;
    end else begin
      r_count_vld <= w_win_end;
      case (r_state)
        ST_IDLE: begin
          r_settle <= '0;
        end
        ST_SETTLE: begin
          // Edges here are ignored while the synchroniser history settles.
          r_settle  <= r_settle + c_SET_W'(1);
          r_timer   <= '0;
          r_acc     <= '0;
          r_ovf_acc <= 1'b0;
        end
        ST_GATE: begin
          r_timer <= r_timer + LOG2GATE'(1);
          if (w_win_end) begin
            r_edge_count <= w_edge ? w_acc_inc : r_acc;
            r_count_ovf  <= r_ovf_acc | (w_acc_full & w_edge);
            r_acc        <= '0;
            r_ovf_acc    <= 1'b0;
          end else if (w_edge) begin
            r_acc <= w_acc_inc;
            if (w_acc_full) r_ovf_acc <= 1'b1;
          end
        end
        default: begin
          r_settle <= '0;
        end
      endcase
    end
  end

  assign edge_count = r_edge_count;
  assign count_ovf  = r_count_ovf;
  assign count_vld  = r_count_vld;
  assign busy       = w_busy;

endmodule
`default_nettype wire
